instruction_fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS pipeline: holds the program counter, owns the 128-word instruction memory, and drives the PC/instruction pair that the IF/ID pipeline register captures on the falling edge. It accepts program loading from the debug unit, redirects on jumps/branches resolved in ID, honours pipeline stalls, and stops issuing on the halt opcode.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/instruction_memory.sv | 36 +++
 rtl/instruction_fetch_unit.sv | 150 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e       : fetch sequencer states (IDLE after reset, RUN, HALT)
//   HALT_OPCODE_DEFAULT : instruction word that ends execution
//   NOP                 : word driven to IF/ID whenever no instruction is issued
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] HALT_OPCODE_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP                 = 32'h0000_0000;

endpackage

// File: rtl/instruction_memory.sv
// Instruction store for the fetch stage: 2^NB_PC words of NB_DATA bits.
// Read is combinational from read_addr; write happens on the rising clock
// edge when write_en is high. Contents are deliberately not reset so a
// loaded program survives a pipeline reset.
// Ports:
//   clk        in  1        write clock
//   write_en   in  1        store write_data at write_addr
//   write_addr in  NB_PC    write word address
//   write_data in  NB_DATA  word to store
//   read_addr  in  NB_PC    read word address
//   read_data  out NB_DATA  mem[read_addr]
module instruction_memory #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_PC   = 7
) (
  input  logic               clk,
  input  logic               write_en,
  input  logic [NB_PC-1:0]   write_addr,
  input  logic [NB_DATA-1:0] write_data,
  input  logic [NB_PC-1:0]   read_addr,
  output logic [NB_DATA-1:0] read_data
);

  localparam int unsigned DEPTH = 2 ** NB_PC;

  logic [NB_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage of the MIPS pipeline. Holds the PC, owns the
// instruction memory and presents the PC+1 / instruction pair captured by
// the IF/ID register on the falling edge. Programs are loaded by the debug
// unit while not running; jumps and taken branches resolved in ID redirect
// the PC; a stall freezes PC and state; the halt word stops issue.
//
// Optional feature macro FETCH_STEP_EN: adds step_i. In RUN the PC only
// advances on cycles with en_pipeline_i && step_i, and instruction_o is NOP
// while step_i is low so IF/ID never sees a duplicate.
//
// Ports:
//   clock_i          in  1        system clock, rising-edge updates
//   reset_n_i        in  1        asynchronous active-low reset
//   en_pipeline_i    in  1        1 = advance, 0 = stall
//   load_en_i        in  1        write load_data_i at load_addr_i (IDLE/HALT)
//   load_addr_i      in  NB_PC    load word address
//   load_data_i      in  NB_DATA  load word
//   start_i          in  1        start execution from PC 0
//   jump_i           in  1        jump redirect
//   jump_target_i    in  NB_PC    jump destination
//   branch_taken_i   in  1        taken-branch redirect
//   branch_target_i  in  NB_PC    branch destination
//   step_i           in  1        (FETCH_STEP_EN only) single-step enable
//   pc_o             out NB_PC    PC+1, wrapping
//   instruction_o    out NB_DATA  fetched word or NOP
//   running_o        out 1        state is RUN
//   halt_o           out 1        state is HALT
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        NB_DATA     = 32,
  parameter int unsigned        NB_PC       = 7,
  parameter logic [NB_DATA-1:0] HALT_OPCODE = NB_DATA'(HALT_OPCODE_DEFAULT)
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               en_pipeline_i,
  input  logic               load_en_i,
  input  logic [NB_PC-1:0]   load_addr_i,
  input  logic [NB_DATA-1:0] load_data_i,
  input  logic               start_i,
  input  logic               jump_i,
  input  logic [NB_PC-1:0]   jump_target_i,
  input  logic               branch_taken_i,
  input  logic [NB_PC-1:0]   branch_target_i,
`ifdef FETCH_STEP_EN
  input  logic               step_i,
`endif
  output logic [NB_PC-1:0]   pc_o,
  output logic [NB_DATA-1:0] instruction_o,
  output logic               running_o,
  output logic               halt_o
);

  fetch_state_e       state_q, state_d;
  logic [NB_PC-1:0]   pc_q, pc_d;
  logic [NB_DATA-1:0] mem_rdata;
  logic               mem_we;
  logic               is_halt_word;
  logic               step_ok;
  logic               advance;

`ifdef FETCH_STEP_EN
  assign step_ok = step_i;
`else
  assign step_ok = 1'b1;
`endif

  assign advance      = en_pipeline_i & step_ok;
  assign is_halt_word = (mem_rdata == HALT_OPCODE);

  instruction_memory #(
    .NB_DATA (NB_DATA),
    .NB_PC   (NB_PC)
  ) u_imem (
    .clk        (clock_i),
    .write_en   (mem_we),
    .write_addr (load_addr_i),
    .write_data (load_data_i),
    .read_addr  (pc_q),
    .read_data  (mem_rdata)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_we        = 1'b0;
    instruction_o = NB_DATA'(NOP);

    unique case (state_q)
      ST_IDLE: begin
        mem_we = load_en_i;
        // A start that coincides with a load is dropped so a half-loaded
        // program is never executed.
        if (start_i && !load_en_i) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end

      ST_RUN: begin
        // The halt word itself is never handed to IF/ID.
        if (step_ok && !is_halt_word) begin
          instruction_o = mem_rdata;
        end
        // A redirect resolved in ID outranks the halt word at the current PC:
        // that word lies on a path that is being abandoned.
        if (advance) begin
          if (jump_i) begin
            pc_d = jump_target_i;
          end else if (branch_taken_i) begin
            pc_d = branch_target_i;
          end else if (is_halt_word) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end

      ST_HALT: begin
        mem_we = load_en_i;
        if (start_i) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  assign pc_o      = pc_q + 1'b1;
  assign running_o = (state_q == ST_RUN);
  assign halt_o    = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

  localparam int unsigned NB_DATA = 32;
  localparam int unsigned NB_PC   = 7;
  localparam logic [31:0] HALT_W  = 32'hFFFF_FFFF;

  logic               clock_i;
  logic               reset_n_i;
  logic               en_pipeline_i;
  logic               load_en_i;
  logic [NB_PC-1:0]   load_addr_i;
  logic [NB_DATA-1:0] load_data_i;
  logic               start_i;
  logic               jump_i;
  logic [NB_PC-1:0]   jump_target_i;
  logic               branch_taken_i;
  logic [NB_PC-1:0]   branch_target_i;
  logic               step_i;
  logic [NB_PC-1:0]   pc_o;
  logic [NB_DATA-1:0] instruction_o;
  logic               running_o;
  logic               halt_o;

  int unsigned errors;
  int unsigned checks;

  instruction_fetch_unit #(
    .NB_DATA     (NB_DATA),
    .NB_PC       (NB_PC),
    .HALT_OPCODE (HALT_W)
  ) dut (
    .clock_i         (clock_i),
    .reset_n_i       (reset_n_i),
    .en_pipeline_i   (en_pipeline_i),
    .load_en_i       (load_en_i),
    .load_addr_i     (load_addr_i),
    .load_data_i     (load_data_i),
    .start_i         (start_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
`ifdef FETCH_STEP_EN
    .step_i          (step_i),
`endif
    .pc_o            (pc_o),
    .instruction_o   (instruction_o),
    .running_o       (running_o),
    .halt_o          (halt_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic load_word(input logic [NB_PC-1:0] addr, input logic [31:0] data);
    load_en_i   = 1'b1;
    load_addr_i = addr;
    load_data_i = data;
    tick();
    load_en_i   = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic do_jump(input logic [NB_PC-1:0] tgt);
    jump_i        = 1'b1;
    jump_target_i = tgt;
    tick();
    jump_i        = 1'b0;
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    reset_n_i       = 1'b0;
    en_pipeline_i   = 1'b1;
    load_en_i       = 1'b0;
    load_addr_i     = '0;
    load_data_i     = '0;
    start_i         = 1'b0;
    jump_i          = 1'b0;
    jump_target_i   = '0;
    branch_taken_i  = 1'b0;
    branch_target_i = '0;
    step_i          = 1'b1;

    #13;
    check("rst_pc", 32'(pc_o), 32'd1);
    check("rst_instr", instruction_o, 32'h0);
    check("rst_running", 32'(running_o), 32'd0);
    check("rst_halt", 32'(halt_o), 32'd0);
    reset_n_i = 1'b1;
    tick();

    // Small program ending in the halt word.
    load_word(7'd0, 32'h2001_0005);
    load_word(7'd1, 32'h2002_0003);
    load_word(7'd2, HALT_W);
    pulse_start();
    check("p0_instr", instruction_o, 32'h2001_0005);
    check("p0_pc", 32'(pc_o), 32'd1);
    check("p0_running", 32'(running_o), 32'd1);
    tick();
    check("p1_instr", instruction_o, 32'h2002_0003);
    check("p1_pc", 32'(pc_o), 32'd2);
    tick();
    check("p2_instr_nop", instruction_o, 32'h0);
    check("p2_pc", 32'(pc_o), 32'd3);
    tick();
    check("halt_flag", 32'(halt_o), 32'd1);
    check("halt_running", 32'(running_o), 32'd0);
    check("halt_instr", instruction_o, 32'h0);
    check("halt_pc", 32'(pc_o), 32'd3);
    tick();
    check("halt_pc_held", 32'(pc_o), 32'd3);

    // Fill every address with a non-halt word (allowed while halted).
    for (int i = 0; i < 128; i++) begin
      load_word(7'(i), 32'h1000_0000 | 32'(i));
    end
    pulse_start();
    check("fill_instr0", instruction_o, 32'h1000_0000);
    check("fill_pc0", 32'(pc_o), 32'd1);
    for (int i = 1; i < 128; i++) begin
      tick();
      check("walk_pc", 32'(pc_o), (32'(i) + 32'd1) & 32'h7F);
    end
    check("wrap_instr127", instruction_o, 32'h1000_007F);
    check("wrap_pc127", 32'(pc_o), 32'd0);
    tick();
    check("wrap_instr0", instruction_o, 32'h1000_0000);
    check("wrap_pc0", 32'(pc_o), 32'd1);

    // Stall at PC 5.
    repeat (5) tick();
    check("pre_stall_pc", 32'(pc_o), 32'd6);
    check("pre_stall_instr", instruction_o, 32'h1000_0005);
    en_pipeline_i = 1'b0;
    jump_i        = 1'b1;
    jump_target_i = 7'd99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", 32'(pc_o), 32'd6);
      check("stall_instr", instruction_o, 32'h1000_0005);
    end
    jump_i        = 1'b0;
    en_pipeline_i = 1'b1;
    tick();
    check("resume_pc", 32'(pc_o), 32'd7);
    check("resume_instr", instruction_o, 32'h1000_0006);

    // Jump beats branch.
    jump_i          = 1'b1;
    jump_target_i   = 7'd40;
    branch_taken_i  = 1'b1;
    branch_target_i = 7'd10;
    tick();
    jump_i         = 1'b0;
    branch_taken_i = 1'b0;
    check("jmp_prio_pc", 32'(pc_o), 32'd41);
    check("jmp_prio_instr", instruction_o, 32'h1000_0028);

    // Reset mid-run at PC 9.
    do_jump(7'd9);
    check("pre_rst_pc", 32'(pc_o), 32'd10);
    #2 reset_n_i = 1'b0;
    #1;
    check("mid_rst_pc", 32'(pc_o), 32'd1);
    check("mid_rst_instr", instruction_o, 32'h0);
    check("mid_rst_running", 32'(running_o), 32'd0);
    check("mid_rst_halt", 32'(halt_o), 32'd0);
    #2 reset_n_i = 1'b1;

    // Start together with a load in IDLE is ignored; the load still lands.
    start_i     = 1'b1;
    load_en_i   = 1'b1;
    load_addr_i = 7'd50;
    load_data_i = HALT_W;
    tick();
    load_en_i = 1'b0;
    check("start_with_load", 32'(running_o), 32'd0);
    tick();
    start_i = 1'b0;
    check("restart_running", 32'(running_o), 32'd1);
    check("restart_mem0", instruction_o, 32'h1000_0000);
    check("restart_pc", 32'(pc_o), 32'd1);

    // Branch away from the halt word at 50.
    do_jump(7'd50);
    check("at_halt_pc", 32'(pc_o), 32'd51);
    check("at_halt_instr", instruction_o, 32'h0);
    branch_taken_i  = 1'b1;
    branch_target_i = 7'd3;
    tick();
    branch_taken_i = 1'b0;
    check("br_over_halt_pc", 32'(pc_o), 32'd4);
    check("br_over_halt_instr", instruction_o, 32'h1000_0003);
    check("br_over_halt_flag", 32'(halt_o), 32'd0);
    check("br_over_halt_run", 32'(running_o), 32'd1);

    // Without a redirect the halt word halts.
    do_jump(7'd50);
    tick();
    check("halt50_flag", 32'(halt_o), 32'd1);
    check("halt50_pc", 32'(pc_o), 32'd51);

`ifdef FETCH_STEP_EN
    pulse_start();
    step_i = 1'b0;
    check("step_low_instr", instruction_o, 32'h0);
    tick();
    check("step_low_pc", 32'(pc_o), 32'd1);
    step_i = 1'b1;
    tick();
    step_i = 1'b0;
    check("step_pulse_pc", 32'(pc_o), 32'd2);
    tick();
    check("step_hold_pc", 32'(pc_o), 32'd2);
    step_i = 1'b1;
    check("step_high_instr", instruction_o, 32'h1000_0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
